// File: rtl/mmu_pmp_scan.sv
// mmu_pmp_scan: sequential PMP checker.
// Walks PMP entries 0..ENTRIES-1 in priority order. Each enabled entry is sent to an
// external single-entry matcher. The first hitting entry's R/W/X/L rules set the
// fault/allow response, which is returned over a valid/ack handshake.
// Optional build macro: MMU_PMP_TIMEOUT_EN adds a 4-bit WAIT watchdog that ends a
// stuck match with a fault response.
module mmu_pmp_scan #(
  parameter int ENTRIES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_paddrProduct_pmp_req_1,
  input  logic [31:0]             i_paddrProduct_pmp_addr_32,
  input  logic [1:0]              i_paddrProduct_pmp_acc_2,
  input  logic                    i_paddrProduct_pmp_priv_1,
  output logic                    o_pmp_paddrProduct_ready_1,
  output logic                    o_pmp_paddrProduct_valid_1,
  output logic                    o_pmp_paddrProduct_fault_1,
  output logic                    o_pmp_paddrProduct_matched_1,
  output logic [3:0]              o_pmp_paddrProduct_entry_4,
  input  logic                    i_paddrProduct_pmp_ack_1,
  input  logic [8*ENTRIES-1:0]    i_csrFetch_pmp_pmpcfg,
  input  logic [32*ENTRIES-1:0]   i_csrFetch_pmp_pmpaddr,
  output logic                    o_pmp_pmpmatch_drive_1,
  output logic [1:0]              o_pmp_pmpmatch_mode_2,
  output logic [31:0]             o_pmp_pmpmatch_addr_32,
  output logic [31:0]             o_pmp_pmpmatch_bottom_32,
  output logic [31:0]             o_pmp_pmpmatch_top_32,
  output logic                    o_pmpmatch_pmp_freenext_1,
  input  logic                    i_pmpmatch_pmp_free_1,
  input  logic                    i_pmpmatch_pmp_drivenext_1,
  input  logic                    i_pmpmatch_pmp_hit_1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [3:0] LAST_IDX = 4'(ENTRIES - 1);

  // CSR views, padded to 16 entries so the 4-bit index always selects in range
  logic [7:0]  cfg_a  [16];
  logic [31:0] paddr_a [16];

  for (genvar g = 0; g < 16; g++) begin : g_csr
    if (g < ENTRIES) begin : g_on
      assign cfg_a[g]   = i_csrFetch_pmp_pmpcfg[8*g +: 8];
      assign paddr_a[g] = i_csrFetch_pmp_pmpaddr[32*g +: 32];
    end else begin : g_off
      assign cfg_a[g]   = '0;
      assign paddr_a[g] = '0;
    end
  end

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  acc_q, acc_d;
  logic        priv_q, priv_d;
  logic        fault_q, fault_d;
  logic        matched_q, matched_d;
  logic [3:0]  entry_q, entry_d;

  logic [7:0]  cur_cfg;
  logic        cur_en;
  logic        cur_last;
  logic        perm_bit;
  logic        hit_fault;
  logic        cfg_unused;

  // Current-entry decode; CSRs are read live, never snapshotted
  always_comb begin
    cur_cfg  = cfg_a[idx_q];
    cur_en   = (cur_cfg[4:3] != 2'b00);
    cur_last = (idx_q == LAST_IDX);
    case (acc_q)
      2'b00:   perm_bit = cur_cfg[0];
      2'b01:   perm_bit = cur_cfg[1];
      2'b10:   perm_bit = cur_cfg[2];
      default: perm_bit = 1'b0;
    endcase
    // Reserved access always faults; otherwise rules apply to S/U or locked entries
    hit_fault = (acc_q == 2'b11) | ((~priv_q | cur_cfg[7]) & ~perm_bit);
  end

  assign cfg_unused = ^cur_cfg[6:5];

`ifdef MMU_PMP_TIMEOUT_EN
  logic [3:0] wdog_q, wdog_d;
`endif

  // Scan FSM: next-state and response capture
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    priv_d    = priv_q;
    fault_d   = fault_q;
    matched_d = matched_q;
    entry_d   = entry_q;
`ifdef MMU_PMP_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_paddrProduct_pmp_req_1) begin
          addr_d  = i_paddrProduct_pmp_addr_32;
          acc_d   = i_paddrProduct_pmp_acc_2;
          priv_d  = i_paddrProduct_pmp_priv_1;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!cur_en) begin
          // Disabled entry: one-cycle skip
          if (cur_last) begin
            state_d   = S_RESP;
            fault_d   = ~priv_q;
            matched_d = 1'b0;
            entry_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (i_pmpmatch_pmp_free_1) begin
          state_d = S_WAIT;
`ifdef MMU_PMP_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (i_pmpmatch_pmp_drivenext_1) begin
          if (i_pmpmatch_pmp_hit_1) begin
            state_d   = S_RESP;
            fault_d   = hit_fault;
            matched_d = 1'b1;
            entry_d   = idx_q;
          end else if (cur_last) begin
            state_d   = S_RESP;
            fault_d   = ~priv_q;
            matched_d = 1'b0;
            entry_d   = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
`ifdef MMU_PMP_TIMEOUT_EN
        else if (wdog_q == 4'd14) begin
          // 15th silent WAIT cycle: give up on this entry with a fault
          state_d   = S_RESP;
          fault_d   = 1'b1;
          matched_d = 1'b0;
          entry_d   = idx_q;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
`endif
      end
      default: begin
        if (i_paddrProduct_pmp_ack_1) state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      priv_q    <= 1'b0;
      fault_q   <= 1'b0;
      matched_q <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      priv_q    <= priv_d;
      fault_q   <= fault_d;
      matched_q <= matched_d;
      entry_q   <= entry_d;
    end
  end

`ifdef MMU_PMP_TIMEOUT_EN
  // WAIT watchdog counter
  always_ff @(posedge clk) begin
    if (!rstn) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`endif

  assign o_pmp_paddrProduct_ready_1   = (state_q == S_IDLE);
  assign o_pmp_paddrProduct_valid_1   = (state_q == S_RESP);
  assign o_pmp_paddrProduct_fault_1   = fault_q;
  assign o_pmp_paddrProduct_matched_1 = matched_q;
  assign o_pmp_paddrProduct_entry_4   = entry_q;

  // Drive is a single-cycle pulse: the same cycle leaves ISSUE for WAIT
  assign o_pmp_pmpmatch_drive_1    = (state_q == S_ISSUE) & cur_en & i_pmpmatch_pmp_free_1;
  assign o_pmp_pmpmatch_mode_2     = cur_cfg[4:3];
  assign o_pmp_pmpmatch_addr_32    = addr_q;
  assign o_pmp_pmpmatch_bottom_32  = (idx_q == 4'd0) ? 32'd0 : paddr_a[idx_q - 4'd1];
  assign o_pmp_pmpmatch_top_32     = paddr_a[idx_q];
  assign o_pmpmatch_pmp_freenext_1 = (state_q == S_WAIT);

endmodule

// File: doc/mmu_pmp_scan.md
# mmu_pmp_scan

Sequential PMP checker that owns the initiator side of the per-entry PMP match interface. It accepts one physical-address check from the address-production stage and walks PMP entries 0..ENTRIES-1 in priority order. For each enabled entry it drives one match request to an external single-entry matcher and collects the hit result. It then applies the R/W/X/L permission rules of the first hitting entry and returns a fault/allow response with a valid/ack handshake.

## Interface
- ENTRIES, 16, number of PMP entries scanned (1..16)
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- i_paddrProduct_pmp_req_1  input  1  check request
- i_paddrProduct_pmp_addr_32  input  32  address in pmpaddr units, passed unchanged to matcher
- i_paddrProduct_pmp_acc_2  input  2  access type: 00 read, 01 write, 10 execute, 11 reserved
- i_paddrProduct_pmp_priv_1  input  1  1 = M-mode
- o_pmp_paddrProduct_ready_1  output  1  request accepted when req&ready at clk edge
- o_pmp_paddrProduct_valid_1  output  1  response valid
- o_pmp_paddrProduct_fault_1  output  1  access fault
- o_pmp_paddrProduct_matched_1  output  1  some entry hit
- o_pmp_paddrProduct_entry_4  output  4  index of hitting (or stalled) entry; 0 on miss
- i_paddrProduct_pmp_ack_1  input  1  response consumed
- i_csrFetch_pmp_pmpcfg  input  8*ENTRIES  cfg byte i at [8i+7:8i]: [0]R [1]W [2]X [4:3]A [7]L
- i_csrFetch_pmp_pmpaddr  input  32*ENTRIES  pmpaddr i at [32i+31:32i]
- o_pmp_pmpmatch_drive_1  output  1  one-cycle match request pulse
- o_pmp_pmpmatch_mode_2  output  2  A field of current entry
- o_pmp_pmpmatch_addr_32  output  32  latched request address
- o_pmp_pmpmatch_bottom_32  output  32  pmpaddr[i-1]; 0 for entry 0
- o_pmp_pmpmatch_top_32  output  32  pmpaddr[i]
- o_pmpmatch_pmp_freenext_1  output  1  scanner can take a result
- i_pmpmatch_pmp_free_1  input  1  matcher can take a drive
- i_pmpmatch_pmp_drivenext_1  input  1  matcher result valid
- i_pmpmatch_pmp_hit_1  input  1  matcher hit, sampled with drivenext

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: ready=1. On req&ready, latch addr/acc/priv, idx=0, go to ISSUE.
- ISSUE: A=00 → skip (idx+1, or RESP-miss if idx=ENTRIES-1), one cycle. A≠00 and free=1 → drive=1 for this cycle only, go to WAIT. A≠00 and free=0 → stay, drive=0.
- WAIT: freenext=1. On drivenext: hit=1 → RESP-hit with entry=idx. Hit=0 → next entry, or RESP-miss at last entry.
- drivenext in any state other than WAIT is ignored.
- mode/bottom/top track the current idx live; CSRs are not snapshotted.
- Hit fault = (priv=0 or L=1) and the permission bit for acc is clear. acc=11 always faults.
- Miss fault = ~priv; matched=0, entry=0.
- RESP: valid=1 with fault/matched/entry held stable until ack; on ack go to IDLE.
- Reset: state IDLE; drive, freenext, valid, fault, matched, entry all 0; ready=1 from the first cycle after reset. Reset mid-scan aborts without a response.

## Timing
- Accept edge ends cycle 0; first ISSUE in cycle 1.
- Each enabled entry costs 1 ISSUE cycle, plus free=0 stall cycles, plus WAIT cycles until drivenext. Each disabled entry costs 1 cycle.
- With all entries enabled, free=1 and drivenext one cycle after drive, a hit at entry k gives valid in cycle 2k+3. A full 16-entry miss gives valid in cycle 33.
- ready is deasserted from cycle 1 until the cycle after ack. Back-to-back: ack edge → ready=1 next cycle.

## Configuration
- MMU_PMP_TIMEOUT_EN defined: a 4-bit watchdog clears on entry to WAIT and counts each WAIT cycle without drivenext.
  - When it reaches 15, go to RESP with fault=1, matched=0, entry=idx.
  - A late drivenext for that entry is then ignored.
- Undefined: WAIT holds indefinitely until drivenext; no counter is implemented.

## Test plan
- ENTRIES=4, cfg0 A=01 R=1, priv=0, acc=00, matcher hits on drive 1 → single drive pulse, valid in cycle 3, fault=0, matched=1, entry=0.
- cfg0 A=00, cfg1 NA4 R-only, acc=01, priv=0, hit on entry 1:
  - Response: fault=1, entry=1.
  - Drive count 1; valid in cycle 4.
- All 4 enabled, matcher never hits:
  - priv=1 → fault=0, matched=0, valid in cycle 9.
  - Repeat with priv=0 → fault=1.
- cfg2 L=1 X=0, priv=1, acc=10, hit on entry 2 → fault=1, entry=2.
- Hold free=0 for 5 cycles in ISSUE, then hold ack low for 3 cycles after valid:
  - No drive while free=0.
  - Outputs stable until ack; ready=1 the cycle after ack.
- Reset asserted mid-WAIT → next cycle valid=0, drive=0, ready=1; a later drivenext produces no response. With MMU_PMP_TIMEOUT_EN, no drivenext → fault=1 after 15 WAIT cycles.
